// File: rtl/clock_pkg.sv
// Shared digit types and limits for the clock's timekeeping and display stages.
package clock_pkg;

    localparam int DIGIT_W = 8;

    typedef logic [DIGIT_W-1:0] digit_t;

    localparam digit_t ONES_MAX = 8'd9;
    localparam digit_t TENS_MAX = 8'd5;

endpackage

// File: rtl/mod60_bcd.sv
// Two-digit BCD counter 00..59 with synchronous clear; wrap flags an increment at 59.
module mod60_bcd
    import clock_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   inc,
    input  logic   clr,
    output digit_t lo,
    output digit_t hi,
    output logic   wrap
);

    digit_t lo_q, lo_d;
    digit_t hi_q, hi_d;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
        lo_d = lo_q;
        hi_d = hi_q;
        wrap = inc && (lo_q == ONES_MAX) && (hi_q == TENS_MAX);
        if (clr) begin
            lo_d = '0;
            hi_d = '0;
        end else if (inc) begin
            if (lo_q == ONES_MAX) begin
                lo_d = '0;
                hi_d = (hi_q == TENS_MAX) ? '0 : hi_q + 8'd1;
            end else begin
                lo_d = lo_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
        if (!rst) begin
            lo_q <= '0;
            hi_q <= '0;
        end else begin
            lo_q <= lo_d;
            hi_q <= hi_d;
        end
    end

    assign lo = lo_q;
    assign hi = hi_q;

endmodule

// File: rtl/min_sec_cnt.sv
// Seconds/minutes stage: 1 Hz prescaler, mm:ss BCD counters, set-mode key handling
// and the registered carry pulse that feeds the hours stage.
module min_sec_cnt
    import clock_pkg::*;
#(
    parameter int CLK_HZ = 1000
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       key_min,
    input  logic       key_sec,
    output logic [7:0] sec_lo,
    output logic [7:0] sec_hi,
    output logic [7:0] min_lo,
    output logic [7:0] min_hi,
    output logic       carryout
);

    localparam int               CNT_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       kmin_q, kmin_d;
    logic [2:0]       ksec_q, ksec_d;
    logic             carry_q, carry_d;

    logic tick;
    logic kmin_edge, ksec_edge;
    logic sec_inc, sec_clr, sec_wrap;
    logic min_inc, min_wrap;

    always_comb begin
        // Set mode suppresses the tick combinationally, so en wins over a coincident tick.
        tick      = !en && (cnt_q == CNT_MAX);
        cnt_d     = (en || tick) ? '0 : cnt_q + 1'b1;

        // Bit 0/1 form the synchronizer, bit 2 remembers the previous synchronized level.
        kmin_d    = {kmin_q[1:0], key_min};
        ksec_d    = {ksec_q[1:0], key_sec};
        kmin_edge = kmin_q[1] & ~kmin_q[2];
        ksec_edge = ksec_q[1] & ~ksec_q[2];

        sec_inc   = tick;
        sec_clr   = en & ksec_edge;
        min_inc   = sec_wrap | (en & kmin_edge);
        carry_d   = sec_wrap & min_wrap;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q   <= '0;
            kmin_q  <= '0;
            ksec_q  <= '0;
            carry_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            kmin_q  <= kmin_d;
            ksec_q  <= ksec_d;
            carry_q <= carry_d;
        end
    end

    mod60_bcd u_sec (
        .clk  (clk),
        .rst  (rst),
        .inc  (sec_inc),
        .clr  (sec_clr),
        .lo   (sec_lo),
        .hi   (sec_hi),
        .wrap (sec_wrap)
    );

    // Minutes only advance from a seconds wrap or a set-mode key, never both at once.
    mod60_bcd u_min (
        .clk  (clk),
        .rst  (rst),
        .inc  (min_inc),
        .clr  (1'b0),
        .lo   (min_lo),
        .hi   (min_hi),
        .wrap (min_wrap)
    );

    assign carryout = carry_q;

endmodule

// File: tb/tb_min_sec_cnt.sv
// Directed bench for min_sec_cnt: a time-level reference model pushes the expected
// mm:ss/carry after every edge and each entry is popped and compared on the next falling edge.
module tb_min_sec_cnt;

    localparam int HZ = 4;

    logic       clk     = 1'b0;
    logic       rst     = 1'b0;
    logic       en      = 1'b0;
    logic       key_min = 1'b0;
    logic       key_sec = 1'b0;
    logic [7:0] sec_lo, sec_hi, min_lo, min_hi;
    logic       carryout;

    min_sec_cnt #(.CLK_HZ(HZ)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .key_min  (key_min),
        .key_sec  (key_sec),
        .sec_lo   (sec_lo),
        .sec_hi   (sec_hi),
        .min_lo   (min_lo),
        .min_hi   (min_hi),
        .carryout (carryout)
    );

    always #5 clk = ~clk;

    int    m_mm, m_ss, m_pcnt, m_ticks, m_carries, seen_carries;
    logic  m_carry;
    bit    pend_min, pend_sec;
    string cur_tag;

    logic [32:0] exp_q[$];
    string       tag_q[$];
    int          chk_cnt, pass_cnt, fail_cnt;

    function automatic logic [32:0] pack_state(int mm, int ss, logic c);
        return {8'(mm / 10), 8'(mm % 10), 8'(ss / 10), 8'(ss % 10), c};
    endfunction

    task automatic check();
        logic [32:0] exp_v, got_v;
        string       tag;
        exp_v = exp_q.pop_front();
        tag   = tag_q.pop_front();
        got_v = {min_hi, min_lo, sec_hi, sec_lo, carryout};
        chk_cnt++;
        assert (got_v === exp_v) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: got %0d%0d:%0d%0d carry=%0b, expected %0d%0d:%0d%0d carry=%0b",
                   tag, got_v[32:25], got_v[24:17], got_v[16:9], got_v[8:1], got_v[0],
                   exp_v[32:25], exp_v[24:17], exp_v[16:9], exp_v[8:1], exp_v[0]);
        end
    endtask

    // One clock edge: advance the reference model, then compare on the falling edge.
    task automatic step();
        @(posedge clk);
        if (!rst) begin
            m_mm = 0; m_ss = 0; m_pcnt = 0; m_carry = 1'b0;
            pend_min = 1'b0; pend_sec = 1'b0;
        end else begin
            bit tick;
            tick    = !en && (m_pcnt == HZ - 1);
            m_carry = 1'b0;
            if (tick) begin
                m_ticks++;
                m_ss++;
                if (m_ss == 60) begin
                    m_ss = 0;
                    m_mm++;
                    if (m_mm == 60) begin
                        m_mm = 0;
                        m_carry = 1'b1;
                        m_carries++;
                    end
                end
            end
            if (en) begin
                if (pend_min) m_mm = (m_mm + 1) % 60;
                if (pend_sec) m_ss = 0;
            end
            pend_min = 1'b0;
            pend_sec = 1'b0;
            m_pcnt   = (en || tick) ? 0 : m_pcnt + 1;
        end
        exp_q.push_back(pack_state(m_mm, m_ss, m_carry));
        tag_q.push_back(cur_tag);
        @(negedge clk);
        if (carryout) seen_carries++;
        check();
    endtask

    task automatic run_ticks(int n);
        int target;
        target = m_ticks + n;
        for (int i = 0; i < (n + 1) * HZ && m_ticks < target; i++) step();
    endtask

    // Stop in the cycle whose closing edge carries a tick (run mode only).
    task automatic to_tick_cycle();
        for (int i = 0; i < HZ && m_pcnt != HZ - 1; i++) step();
    endtask

    // Keys go high before edge k; the action is due at edge k+2.
    task automatic press(bit pm, bit ps, int hold);
        key_min = pm;
        key_sec = ps;
        for (int i = 0; i < hold + 3; i++) begin
            if (i == hold) begin
                key_min = 1'b0;
                key_sec = 1'b0;
            end
            if (i == 2) begin
                pend_min = pm;
                pend_sec = ps;
            end
            step();
        end
    endtask

    initial begin
        chk_cnt = 0; pass_cnt = 0; fail_cnt = 0;
        m_mm = 0; m_ss = 0; m_pcnt = 0; m_ticks = 0; m_carries = 0; seen_carries = 0;
        m_carry = 1'b0; pend_min = 1'b0; pend_sec = 1'b0;

        cur_tag = "reset";
        step();
        step();
        rst = 1'b1;
        cur_tag = "first_tick";
        repeat (HZ) step();

        cur_tag = "to_00_09";
        run_ticks(8);
        cur_tag = "sec_tens";
        run_ticks(1);
        cur_tag = "to_09_59";
        run_ticks(589);
        cur_tag = "min_tens";
        run_ticks(1);
        cur_tag = "to_59_59";
        run_ticks(2999);
        cur_tag = "rollover";
        run_ticks(1);
        step();

        cur_tag = "en_on_tick";
        to_tick_cycle();
        en = 1'b1;
        step();
        cur_tag = "set_no_tick";
        repeat (3 * HZ) step();

        cur_tag = "prep_12_34";
        en = 1'b0;
        run_ticks(34);
        en = 1'b1;
        step();
        repeat (12) press(1'b1, 1'b0, 2);
        cur_tag = "set_min";
        repeat (3) press(1'b1, 1'b0, 2);
        repeat (3 * HZ) step();
        cur_tag = "set_sec_clr";
        press(1'b0, 1'b1, 2);

        cur_tag = "prep_59_10";
        repeat (44) press(1'b1, 1'b0, 2);
        en = 1'b0;
        run_ticks(10);
        en = 1'b1;
        step();
        cur_tag = "set_min_wrap";
        press(1'b1, 1'b0, 2);
        cur_tag = "hold20";
        press(1'b1, 1'b0, 20);
        cur_tag = "both_keys";
        press(1'b1, 1'b1, 2);

        cur_tag = "run_key_ignored";
        en = 1'b0;
        press(1'b1, 1'b1, 2);
        key_min = 1'b1;
        run_ticks(2);
        cur_tag = "held_key_mode_change";
        en = 1'b1;
        repeat (6) step();
        key_min = 1'b0;
        repeat (3) step();

        cur_tag = "prep_59_59";
        for (int i = 0; i < 60 && m_mm != 59; i++) press(1'b1, 1'b0, 2);
        press(1'b0, 1'b1, 2);
        en = 1'b0;
        run_ticks(59);
        cur_tag = "reset_on_carry";
        to_tick_cycle();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        cur_tag = "post_reset_tick";
        repeat (HZ) step();

        chk_cnt++;
        assert (seen_carries === m_carries) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL carry_count: got %0d pulses, expected %0d", seen_carries, m_carries);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
